// File: rtl/alm_log_conv_arbiter.sv
// Round-robin arbiter sharing one ALM log-conversion datapath (LOD, encode, fraction justify)
// between N_REQ requesters; 2-stage pipeline. Define ALM_CONV_PERF_EN for perf counters.
module alm_log_conv_arbiter #(
    parameter int A_BW       = 32,
    parameter int N_REQ      = 4,
    parameter int LOG2_WIDTH = $clog2(A_BW),
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*A_BW-1:0]        req_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LOG2_WIDTH+A_BW-2:0]   out_log,
    output logic                         out_zero,
    output logic [ID_W-1:0]              out_id
`ifdef ALM_CONV_PERF_EN
    ,
    output logic [31:0]                  perf_accept_cnt,
    output logic [31:0]                  perf_stall_cnt
`endif
);

    localparam int LOG_W = LOG2_WIDTH + A_BW - 1;

    // k = position of the leading one; the bits below it become the left-justified fraction.
    // A zero operand naturally yields k=0 and an all-zero fraction.
    function automatic logic [LOG_W-1:0] alm_conv(input logic [A_BW-1:0] a);
        logic [LOG2_WIDTH-1:0] k;
        logic [A_BW-1:0]       shifted;
        k = {LOG2_WIDTH{1'b0}};
        for (int i = 0; i < A_BW; i++) begin
            k = a[i] ? LOG2_WIDTH'(i) : k;
        end
        shifted = a << (LOG2_WIDTH'(A_BW - 1) - k);
        return {k, shifted[A_BW-2:0]};
    endfunction

    logic [A_BW-1:0]  req_op_s [N_REQ];
    logic [N_REQ-1:0] grant_s;
    logic             grant_any_s;
    logic [ID_W-1:0]  grant_idx_s;
    logic [A_BW-1:0]  sel_data_s;
    logic             s0_accept_s;
    logic             s1_accept_s;

    logic [ID_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic             s0_v_q,    s0_v_d;
    logic [A_BW-1:0]  s0_data_q, s0_data_d;
    logic [ID_W-1:0]  s0_id_q,   s0_id_d;
    logic             s1_v_q,    s1_v_d;
    logic [LOG_W-1:0] s1_log_q,  s1_log_d;
    logic             s1_zero_q, s1_zero_d;
    logic [ID_W-1:0]  s1_id_q,   s1_id_d;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_op_s[g] = req_data[g*A_BW +: A_BW];
    end

    assign s1_accept_s = ~s1_v_q | out_ready;
    assign s0_accept_s = ~s0_v_q | s1_accept_s;
    assign req_ready   = grant_s & {N_REQ{s0_accept_s}};

    // Round-robin search starting one past the last accepted requester.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand        = {ID_W{1'b0}};
        grant_s     = {N_REQ{1'b0}};
        grant_any_s = 1'b0;
        grant_idx_s = {ID_W{1'b0}};
        sel_data_s  = {A_BW{1'b0}};
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
            if (!grant_any_s && req_valid[cand]) begin
                grant_any_s    = 1'b1;
                grant_idx_s    = cand;
                grant_s[cand]  = 1'b1;
                sel_data_s     = req_op_s[cand];
            end else begin
                grant_any_s    = grant_any_s;
            end
        end
    end

    // Pipeline next state: S0 captures the granted operand, S1 the converted result.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        s0_v_d    = s0_v_q;
        s0_data_d = s0_data_q;
        s0_id_d   = s0_id_q;
        s1_v_d    = s1_v_q;
        s1_log_d  = s1_log_q;
        s1_zero_d = s1_zero_q;
        s1_id_d   = s1_id_q;
        if (s0_accept_s) begin
            s0_v_d = grant_any_s;
            if (grant_any_s) begin
                rr_ptr_d  = grant_idx_s;
                s0_data_d = sel_data_s;
                s0_id_d   = grant_idx_s;
            end else begin
                rr_ptr_d  = rr_ptr_q;
            end
        end else begin
            s0_v_d = s0_v_q;
        end
        if (s1_accept_s) begin
            s1_v_d = s0_v_q;
            if (s0_v_q) begin
                s1_log_d  = alm_conv(s0_data_q);
                s1_zero_d = (s0_data_q == {A_BW{1'b0}});
                s1_id_d   = s0_id_q;
            end else begin
                s1_log_d  = s1_log_q;
            end
        end else begin
            s1_v_d = s1_v_q;
        end
    end

    // State registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= ID_W'(N_REQ - 1);
            s0_v_q    <= 1'b0;
            s0_data_q <= {A_BW{1'b0}};
            s0_id_q   <= {ID_W{1'b0}};
            s1_v_q    <= 1'b0;
            s1_log_q  <= {LOG_W{1'b0}};
            s1_zero_q <= 1'b0;
            s1_id_q   <= {ID_W{1'b0}};
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            s0_v_q    <= s0_v_d;
            s0_data_q <= s0_data_d;
            s0_id_q   <= s0_id_d;
            s1_v_q    <= s1_v_d;
            s1_log_q  <= s1_log_d;
            s1_zero_q <= s1_zero_d;
            s1_id_q   <= s1_id_d;
        end
    end

    assign out_valid = s1_v_q;
    assign out_log   = s1_log_q;
    assign out_zero  = s1_zero_q;
    assign out_id    = s1_id_q;

`ifdef ALM_CONV_PERF_EN
    logic [31:0] perf_accept_q;
    logic [31:0] perf_stall_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_accept_q <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else begin
            if (grant_any_s && s0_accept_s && (perf_accept_q != 32'hFFFF_FFFF)) begin
                perf_accept_q <= perf_accept_q + 32'd1;
            end else begin
                perf_accept_q <= perf_accept_q;
            end
            if (s1_v_q && !out_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end else begin
                perf_stall_q <= perf_stall_q;
            end
        end
    end

    assign perf_accept_cnt = perf_accept_q;
    assign perf_stall_cnt  = perf_stall_q;
`endif

endmodule
